led_ctrl: RTL and testbench

LED_CTRL -- requirements
Module: led_ctrl

---
 rtl/led_ctrl_pkg.sv | 14 +
 rtl/led_ctrl_led.sv | 16 +
 rtl/led_ctrl.sv | 100 ++++++++++
 tb/tb_led_ctrl.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/led_ctrl_pkg.sv
// Shared definitions for the LED snake-game controller: state encoding and LED bar width.
package led_ctrl_pkg;

  localparam int unsigned LED_W = 6;
  localparam int unsigned LEN_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_WIN  = 2'd2,
    ST_LOSE = 2'd3
  } state_t;

endpackage

// File: rtl/led_ctrl_led.sv
// Length-to-pattern decode: one LED goes dark for each food eaten, all dark at LED_W or more.
module led_ctrl_led
  import led_ctrl_pkg::*;
(
  input  logic [LEN_W-1:0] length,
  output logic [LED_W-1:0] pattern
);

  always_comb begin
    pattern = '0;
    if (32'(length) < LED_W) begin
      pattern = {LED_W{1'b1}} >> length;
    end
  end

endmodule

// File: rtl/led_ctrl.sv
// Game controller: IDLE/PLAY/WIN/LOSE FSM with food counter and end-of-game blink timer.
module led_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int unsigned MAX_LEN      = 6,
  parameter int unsigned BLINK_CYCLES = 25_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             eat,
  input  logic             hit,
  output logic [LEN_W-1:0] length,
  output logic [LED_W-1:0] led,
  output logic [1:0]       state,
  output logic             game_over
);

  localparam int unsigned CNT_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               phase_q, phase_d;
  logic [LED_W-1:0]   pattern;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b1;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  // Blink timer free-runs only in WIN/LOSE; entering either state restarts it at phase 1.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = '0;
    phase_d = 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_PLAY;
          len_d   = '0;
        end
      end
      ST_PLAY: begin
        if (hit) begin
          state_d = ST_LOSE;
        end else if (eat && (32'(len_q) < MAX_LEN)) begin
          len_d = LEN_W'(len_q + LEN_W'(1));
          if (32'(len_q) + 1 == MAX_LEN) begin
            state_d = ST_WIN;
          end
        end
      end
      ST_WIN, ST_LOSE: begin
        if (start) begin
          state_d = ST_PLAY;
          len_d   = '0;
        end else if (cnt_q == CNT_W'(BLINK_CYCLES - 1)) begin
          cnt_d   = '0;
          phase_d = ~phase_q;
        end else begin
          cnt_d   = CNT_W'(cnt_q + CNT_W'(1));
          phase_d = phase_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  led_ctrl_led u_decode (
    .length  (len_q),
    .pattern (pattern)
  );

  always_comb begin
    led = {LED_W{1'b1}};
    unique case (state_q)
      ST_IDLE: led = {LED_W{1'b1}};
      ST_PLAY: led = pattern;
      ST_WIN:  led = phase_q ? {LED_W{1'b1}} : '0;
      ST_LOSE: led = phase_q ? pattern : '0;
      default: led = {LED_W{1'b1}};
    endcase
  end

  assign length    = len_q;
  assign state     = state_q;
  assign game_over = (state_q == ST_WIN) || (state_q == ST_LOSE);

endmodule

// File: tb/tb_led_ctrl.sv
// Directed bench for led_ctrl with BLINK_CYCLES=4, MAX_LEN=6; expectations queued per step.
module tb_led_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, eat, hit;
  logic [2:0] length;
  logic [5:0] led_o;
  logic [1:0] st_o;
  logic       game_over;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      tag;
    logic [2:0] len;
    logic [5:0] led;
    logic [1:0] st;
    logic       go;
  } exp_t;

  exp_t sb[$];

  localparam logic [1:0] IDLE = 2'd0, PLAY = 2'd1, WIN = 2'd2, LOSE = 2'd3;

  led_ctrl #(.MAX_LEN(6), .BLINK_CYCLES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .eat       (eat),
    .hit       (hit),
    .length    (length),
    .led       (led_o),
    .state     (st_o),
    .game_over (game_over)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic push_exp(input string tag, input logic [2:0] len, input logic [5:0] ld,
                          input logic [1:0] st, input logic go);
    exp_t e;
    e.tag = tag; e.len = len; e.led = ld; e.st = st; e.go = go;
    sb.push_back(e);
  endtask

  task automatic pop_chk();
    exp_t e;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL scoreboard: observed empty queue, expected an entry");
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checks++;
      assert (st_o === e.st) else begin
        errors++;
        $error("FAIL %s state: observed %0d expected %0d", e.tag, st_o, e.st);
      end
      checks++;
      assert (length === e.len) else begin
        errors++;
        $error("FAIL %s length: observed %0d expected %0d", e.tag, length, e.len);
      end
      checks++;
      assert (led_o === e.led) else begin
        errors++;
        $error("FAIL %s led: observed %b expected %b", e.tag, led_o, e.led);
      end
      checks++;
      assert (game_over === e.go) else begin
        errors++;
        $error("FAIL %s game_over: observed %b expected %b", e.tag, game_over, e.go);
      end
    end
  endtask

  task automatic step(input logic s, input logic e, input logic h, input string tag,
                      input logic [2:0] len, input logic [5:0] ld,
                      input logic [1:0] st, input logic go);
    @(negedge clk);
    start = s; eat = e; hit = h;
    push_exp(tag, len, ld, st, go);
    @(posedge clk);
    #1;
    pop_chk();
    start = 1'b0; eat = 1'b0; hit = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; eat = 1'b0; hit = 1'b0;
    #1;
    push_exp("reset", 3'd0, 6'b111111, IDLE, 1'b0);
    pop_chk();
    @(negedge clk);
    rst = 1'b0;

    step(0, 1, 0, "idle_eat", 3'd0, 6'b111111, IDLE, 1'b0);
    step(0, 0, 1, "idle_hit", 3'd0, 6'b111111, IDLE, 1'b0);
    step(1, 0, 0, "start", 3'd0, 6'b111111, PLAY, 1'b0);
    step(0, 1, 0, "eat1", 3'd1, 6'b011111, PLAY, 1'b0);
    step(0, 0, 0, "hold1", 3'd1, 6'b011111, PLAY, 1'b0);
    step(0, 1, 0, "eat2", 3'd2, 6'b001111, PLAY, 1'b0);
    step(0, 1, 0, "eat3", 3'd3, 6'b000111, PLAY, 1'b0);
    step(1, 0, 0, "play_start", 3'd3, 6'b000111, PLAY, 1'b0);
    step(0, 1, 0, "eat4", 3'd4, 6'b000011, PLAY, 1'b0);
    step(0, 1, 0, "eat5", 3'd5, 6'b000001, PLAY, 1'b0);
    step(0, 1, 0, "win_entry", 3'd6, 6'b111111, WIN, 1'b1);
    step(0, 1, 0, "win_b1", 3'd6, 6'b111111, WIN, 1'b1);
    step(0, 0, 1, "win_b2", 3'd6, 6'b111111, WIN, 1'b1);
    step(0, 0, 0, "win_b3", 3'd6, 6'b111111, WIN, 1'b1);
    step(0, 0, 0, "win_off4", 3'd6, 6'b000000, WIN, 1'b1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, "win_off", 3'd6, 6'b000000, WIN, 1'b1);
    step(0, 0, 0, "win_on8", 3'd6, 6'b111111, WIN, 1'b1);

    step(1, 0, 0, "restart", 3'd0, 6'b111111, PLAY, 1'b0);
    step(0, 1, 0, "l_eat1", 3'd1, 6'b011111, PLAY, 1'b0);
    step(0, 1, 0, "l_eat2", 3'd2, 6'b001111, PLAY, 1'b0);
    step(0, 1, 1, "eat_hit", 3'd2, 6'b001111, LOSE, 1'b1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, "lose_on", 3'd2, 6'b001111, LOSE, 1'b1);
    step(0, 1, 0, "lose_off4", 3'd2, 6'b000000, LOSE, 1'b1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, "lose_off", 3'd2, 6'b000000, LOSE, 1'b1);
    step(0, 0, 0, "lose_on8", 3'd2, 6'b001111, LOSE, 1'b1);
    step(1, 0, 1, "lose_start_hit", 3'd0, 6'b111111, PLAY, 1'b0);

    step(0, 1, 0, "w_eat1", 3'd1, 6'b011111, PLAY, 1'b0);
    step(0, 1, 0, "w_eat2", 3'd2, 6'b001111, PLAY, 1'b0);
    step(0, 1, 0, "w_eat3", 3'd3, 6'b000111, PLAY, 1'b0);
    step(0, 1, 0, "w_eat4", 3'd4, 6'b000011, PLAY, 1'b0);
    step(0, 1, 0, "w_eat5", 3'd5, 6'b000001, PLAY, 1'b0);
    step(0, 1, 0, "w_win", 3'd6, 6'b111111, WIN, 1'b1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, "w_blink", 3'd6, (i == 3) ? 6'b000000 : 6'b111111, WIN, 1'b1);

    #2;
    rst = 1'b1;
    #1;
    push_exp("async_rst", 3'd0, 6'b111111, IDLE, 1'b0);
    pop_chk();
    @(negedge clk);
    rst = 1'b0;
    step(0, 1, 0, "post_rst_eat", 3'd0, 6'b111111, IDLE, 1'b0);
    step(1, 0, 0, "post_rst_start", 3'd0, 6'b111111, PLAY, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
